seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 114 +++++++++++
 tb/tb_seq_shifter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: shifts a captured operand by up to STEP bits
// per cycle (SLL/SRL/SRA/ROL) and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a new request
// SHIFT | working register being shifted, rem_q bits left to go
// DONE  | result on data_o, waiting for out_ready_i
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         mode_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] STEP_L  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_L = (SHAMT_W+1)'(WIDTH);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [1:0]         mode_q, mode_d;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   shifted;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            work_q  <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    // SRA keeps the operand MSB in place, so replicating work_q's MSB each step
    // is equivalent to replicating the originally captured sign bit.
    always_comb begin
        k = (rem_q > STEP_L) ? STEP_L : rem_q;
        shifted = work_q;
        case (mode_q)
            2'b00:   shifted = work_q << k;
            2'b01:   shifted = work_q >> k;
            2'b10:   shifted = WIDTH'($signed(work_q) >>> k);
            default: shifted = (work_q << k) | (work_q >> (WIDTH_L - {1'b0, k}));
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        work_d  = work_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    work_d  = data_i;
                    mode_d  = mode_i;
                    rem_d   = shamt_i;
                    state_d = (shamt_i == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - k;
                if (rem_q == k) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        data_o      = work_q;
        case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_DONE:  out_valid_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter (WIDTH=32, STEP=4) against a
// whole-operand reference model.
module tb_seq_shifter;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic [WIDTH-1:0]   data_i = '0;
    logic [SHAMT_W-1:0] shamt_i = '0;
    logic [1:0]         mode_i = 2'b00;
    logic               out_valid_o;
    logic               out_ready_i = 1'b0;
    logic [WIDTH-1:0]   data_o;
    logic               busy_o;

    int total = 0;
    int bad   = 0;

    seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .shamt_i     (shamt_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(logic [31:0] d, int sh, logic [1:0] m);
        logic [63:0] w;
        case (m)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: begin
                w = {d, d} << sh;
                return w[63:32];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        in_valid_i = 1'($urandom);
        data_i     = $urandom;
        shamt_i    = SHAMT_W'($urandom);
        mode_i     = 2'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_req(input logic [31:0] d, input int sh, input logic [1:0] m,
                           input int hold, input string tag);
        logic [31:0] exp;
        int cyc;
        exp = ref_shift(d, sh, m);
        in_valid_i = 1'b1;
        data_i     = d;
        shamt_i    = SHAMT_W'(sh);
        mode_i     = m;
        out_ready_i = 1'b0;
        chk({tag, ".ready_before"}, 32'(in_ready_o), 32'd1);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            scramble();
            if (!out_valid_o) out_ready_i = 1'($urandom);
        end while (!out_valid_o && cyc < 40);
        out_ready_i = 1'b0;
        chk({tag, ".latency"}, 32'(cyc), 32'(1 + (sh + STEP - 1) / STEP));
        chk({tag, ".data"}, data_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid_i = ~in_valid_i;
            data_i     = $urandom;
            chk({tag, ".hold_data"}, data_o, exp);
            chk({tag, ".hold_valid"}, 32'(out_valid_o), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        chk({tag, ".idle_ready"}, 32'(in_ready_o), 32'd1);
        chk({tag, ".idle_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst.ready", 32'(in_ready_o), 32'd1);
        chk("rst.valid", 32'(out_valid_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.data", data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(32'h0000_0001, 2, 2'b00, 0, "sll2");
        run_req(32'h8000_0000, 31, 2'b10, 0, "sra31");
        run_req(32'h8000_0000, 31, 2'b01, 0, "srl31");
        run_req(32'h8000_0001, 4, 2'b11, 0, "rol4");
        run_req(32'hDEAD_BEEF, 0, 2'b01, 0, "srl0");
        run_req(32'h1234_5678, 13, 2'b11, 5, "bp");

        // Reset two cycles into a long shift
        in_valid_i = 1'b1;
        data_i     = 32'hF0F0_1234;
        shamt_i    = 5'd31;
        mode_i     = 2'b10;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("mid.busy_pre", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.valid", 32'(out_valid_o), 32'd0);
        chk("mid.busy", 32'(busy_o), 32'd0);
        chk("mid.data", data_o, 32'd0);
        chk("mid.ready", 32'(in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("mid.no_result", 32'(out_valid_o), 32'd0);
        end
        run_req(32'h8765_4321, 7, 2'b00, 1, "post_rst");

        for (int n = 0; n < 24; n++) begin
            run_req($urandom, int'($urandom_range(0, 31)), 2'($urandom),
                    int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
